register_univ: RTL and testbench

- Parametrised successor to the fixed 4-bit enable/reset register in the 3-stage processor datapath.
- Holds a WIDTH-bit value and supports eight operations selected by a mode field: hold, parallel load, shift left/right with serial input, rotate left/right, increment and decrement.
- Provides a registered carry/shift-out flag and a combinational zero flag.
- Used for the program counter, shift-based ALU helpers and loop counters.

---
 rtl/register_univ.sv | 109 ++++++++++
 tb/tb_register_univ.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/register_univ.sv
// Universal WIDTH-bit register: hold, load, shift, rotate, increment, decrement.
// Optional macro REGISTER_UNIV_SAT_EN makes INC/DEC saturate instead of wrapping.
module register_univ #(
  parameter int unsigned          WIDTH     = 4,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             zero
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_INC  = 3'b110,
    OP_DEC  = 3'b111
  } op_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             cout_q, cout_d;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH-1:0] dec_val;
  op_e              op;

  assign op      = op_e'(mode);
  assign inc_sum = {1'b0, q_q} + {1'b0, ONE};
  assign dec_val = q_q - ONE;

  always_comb begin
    q_d    = q_q;
    cout_d = cout_q;
    if (en) begin
      // Unknown or X mode falls through to default and holds state.
      case (op)
        OP_HOLD: ;
        OP_LOAD: begin
          q_d    = d;
          cout_d = 1'b0;
        end
        OP_SHL: begin
          q_d    = {q_q[WIDTH-2:0], sin};
          cout_d = q_q[WIDTH-1];
        end
        OP_SHR: begin
          q_d    = {sin, q_q[WIDTH-1:1]};
          cout_d = q_q[0];
        end
        OP_ROL: begin
          q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          cout_d = q_q[WIDTH-1];
        end
        OP_ROR: begin
          q_d    = {q_q[0], q_q[WIDTH-1:1]};
          cout_d = q_q[0];
        end
        OP_INC: begin
`ifdef REGISTER_UNIV_SAT_EN
          if (&q_q) begin
            q_d    = q_q;
            cout_d = 1'b1;
          end else begin
            q_d    = inc_sum[WIDTH-1:0];
            cout_d = 1'b0;
          end
`else
          q_d    = inc_sum[WIDTH-1:0];
          cout_d = inc_sum[WIDTH];
`endif
        end
        OP_DEC: begin
          cout_d = (q_q == '0);
`ifdef REGISTER_UNIV_SAT_EN
          q_d    = (q_q == '0) ? q_q : dec_val;
`else
          q_d    = dec_val;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      q_q    <= RESET_VAL;
      cout_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cout_q <= cout_d;
    end
  end

  assign q    = q_q;
  assign cout = cout_q;
  assign zero = (q_q == '0);

endmodule

// File: tb/tb_register_univ.sv
// Randomized + directed bench for register_univ against an arithmetic reference model.
module tb_register_univ;

  localparam int W = 4;
  localparam int M = 16;

  logic         clk = 1'b0;
  logic         res, en, sin;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic [W-1:0] q, q5;
  logic         cout, cout5, zero, zero5;

  int checks = 0;
  int errors = 0;
  int mq, mc;

  register_univ #(.WIDTH(W), .RESET_VAL(4'h0)) u_dut (
    .clk(clk), .res(res), .en(en), .mode(mode), .d(d), .sin(sin),
    .q(q), .cout(cout), .zero(zero)
  );

  register_univ #(.WIDTH(W), .RESET_VAL(4'h5)) u_dut5 (
    .clk(clk), .res(res), .en(en), .mode(mode), .d(d), .sin(sin),
    .q(q5), .cout(cout5), .zero(zero5)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference behaviour in plain integer arithmetic.
  task automatic model(input bit r, input bit e, input int md, input int dv, input bit s);
    int nq, nc;
    nq = mq; nc = mc;
    if (r) begin
      nq = 0; nc = 0;
    end else if (e) begin
      case (md)
        1: begin nq = dv; nc = 0; end
        2: begin nq = (mq * 2 + s) % M;             nc = mq / (M/2); end
        3: begin nq = mq / 2 + s * (M/2);           nc = mq % 2; end
        4: begin nq = (mq * 2) % M + mq / (M/2);    nc = mq / (M/2); end
        5: begin nq = mq / 2 + (mq % 2) * (M/2);    nc = mq % 2; end
        6: begin
`ifdef REGISTER_UNIV_SAT_EN
          if (mq == M-1) begin nq = M-1; nc = 1; end
          else begin nq = mq + 1; nc = 0; end
`else
          nq = (mq + 1) % M; nc = (mq + 1) / M;
`endif
        end
        7: begin
`ifdef REGISTER_UNIV_SAT_EN
          if (mq == 0) begin nq = 0; nc = 1; end
          else begin nq = mq - 1; nc = 0; end
`else
          nq = (mq + M - 1) % M; nc = (mq == 0) ? 1 : 0;
`endif
        end
        default: ;
      endcase
    end
    mq = nq; mc = nc;
  endtask

  task automatic step(input string tag, input bit r, input bit e, input int md,
                      input int dv, input bit s);
    res = r; en = e; mode = 3'(md); d = 4'(dv); sin = s;
    @(posedge clk);
    #1;
    model(r, e, md, dv, s);
    check({tag, ".q"}, int'(q), mq);
    check({tag, ".cout"}, int'(cout), mc);
    check({tag, ".zero"}, int'(zero), (mq == 0) ? 1 : 0);
  endtask

  initial begin
    mq = 0; mc = 0;
    res = 1'b1; en = 1'b0; mode = 3'd0; d = '0; sin = 1'b0;

    // 1: reset from q=A, cout=1
    step("rst0", 1, 0, 0, 0, 0);
    step("ld_d", 0, 1, 1, 4'hD, 0);
    step("shl_a", 0, 1, 2, 0, 0);
    check("pre_rst_q", int'(q), 4'hA);
    check("pre_rst_c", int'(cout), 1);
    step("rst1", 1, 0, 3, 0, 1);
    check("rst1_q_lit", int'(q), 0);
    check("rst5_q", int'(q5), 5);
    check("rst5_cout", int'(cout5), 0);
    check("rst5_zero", int'(zero5), 0);

    // 2: load then disabled INC
    step("ld9", 0, 1, 1, 4'b1001, 0);
    for (int i = 0; i < 3; i++) step("en0", 0, 0, 6, 4'hF, 1);
    check("en0_q_lit", int'(q), 4'b1001);

    // 3: shift / rotate sequence
    step("shl", 0, 1, 2, 0, 0);
    check("shl_lit", int'(q), 4'b0010);
    step("shr", 0, 1, 3, 0, 1);
    check("shr_lit", int'(q), 4'b1001);
    step("ror", 0, 1, 5, 0, 0);
    check("ror_lit", int'(q), 4'b1100);
    step("rol", 0, 1, 4, 0, 0);
    check("rol_lit", int'(q), 4'b1001);
    check("rol_c_lit", int'(cout), 1);

    // 4: increment wrap / saturate, decrement borrow
    step("ldE", 0, 1, 1, 4'hE, 0);
    step("inc1", 0, 1, 6, 0, 0);
    check("inc1_lit", int'(q), 4'hF);
    step("inc2", 0, 1, 6, 0, 0);
    check("inc2_c_lit", int'(cout), 1);
    step("ld0", 0, 1, 1, 0, 0);
    step("dec0", 0, 1, 7, 0, 0);
    check("dec0_c_lit", int'(cout), 1);

    // 5: reset beats load
    step("rst_ld", 1, 1, 1, 4'h7, 0);
    check("rst_ld_lit", int'(q), 0);

    // 6: HOLD after SHL sets cout
    step("ld8", 0, 1, 1, 4'h8, 0);
    step("shl8", 0, 1, 2, 0, 1);
    for (int i = 0; i < 4; i++) step("hold", 0, 1, 0, 4'h3, 0);
    check("hold_c_lit", int'(cout), 1);
    check("hold_q_lit", int'(q), 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
